// File: rtl/cmd_credit_pool_ctrl.sv
// Per-channel command credit pools with a round-robin issue grant.
// Quotas are latched on cfg_load and clamped to min(croom, CREDITS_MAX).
// Counters drop when a grant issues and rise when a response returns.
// Drain stops new grants and waits for every credit to come home.
module cmd_credit_pool_ctrl #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned CREDITS_MAX  = 64,
  parameter int unsigned CNT_W        = $clog2(CREDITS_MAX) + 1,
  localparam int unsigned CH_W        = $clog2(NUM_CHANNELS)
) (
  input  logic                          clock,
  input  logic                          rstn,
  input  logic                          enabled,
  input  logic [7:0]                    croom,
  input  logic [NUM_CHANNELS*CNT_W-1:0] cfg_credits,
  input  logic                          cfg_load,
  input  logic [NUM_CHANNELS-1:0]       req_valid,
  output logic [NUM_CHANNELS-1:0]       grant,
  input  logic                          rsp_valid,
  input  logic [CH_W-1:0]               rsp_channel,
  input  logic                          drain_req,
  output logic                          drain_done,
  output logic [NUM_CHANNELS*CNT_W-1:0] credits_avail,
  output logic                          cfg_error
);

  localparam int unsigned SUM_W = CNT_W + 2;

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StDrain, StDrained} state_e;

  state_e state_q, state_d;

  logic [NUM_CHANNELS-1:0][CNT_W-1:0] cfg_q, quota_q, quota_d, count_q, count_d, clamped;
  logic [NUM_CHANNELS-1:0]            grant_q, grant_d, eligible, rsp_hit;
  logic [CH_W-1:0]                    ptr_q, ptr_d, idx;
  logic                               err_q, err_d, found, cfg_accept, all_home;
  logic [SUM_W-1:0]                   limit, sum, remaining;

  // cfg_load is only honoured while no pool is live
  assign cfg_accept = enabled & cfg_load & ((state_q == StIdle) | (state_q == StDrained));
  assign all_home   = (count_d == quota_q);

  // State register
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic; dropping enabled wins over everything
  always_comb begin
    state_d = state_q;
    if (!enabled) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    if (cfg_load) state_d = StLoad;
        StLoad:    state_d = StRun;
        StRun:     if (drain_req) state_d = StDrain;
        StDrain:   if (all_home) state_d = StDrained;
        StDrained: begin
          if (cfg_load)        state_d = StLoad;
          else if (!drain_req) state_d = StRun;
        end
        default:   state_d = StIdle;
      endcase
    end
  end

  // Outputs; grant is masked by enabled in the same cycle
  always_comb begin
    grant         = grant_q & {NUM_CHANNELS{enabled}};
    drain_done    = (state_q == StDrained);
    cfg_error     = err_q;
    credits_avail = count_q;
  end

  // Clamp quotas in channel order so the total never exceeds the limit
  always_comb begin
    limit = SUM_W'(croom);
    if (limit > SUM_W'(CREDITS_MAX)) limit = SUM_W'(CREDITS_MAX);
    sum       = '0;
    remaining = limit;
    clamped   = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      sum = sum + SUM_W'(cfg_q[i]);
      if (SUM_W'(cfg_q[i]) <= remaining) begin
        clamped[i] = cfg_q[i];
        remaining  = remaining - SUM_W'(cfg_q[i]);
      end else begin
        // remaining never exceeds CREDITS_MAX, so it fits in CNT_W bits
        clamped[i] = remaining[CNT_W-1:0];
        remaining  = '0;
      end
    end
  end

  // Round-robin pick; a channel whose last credit is already being granted is skipped
  always_comb begin
    grant_d = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      eligible[i] = req_valid[i] & (count_q[i] != CNT_W'(grant_q[i]));
    end
    if (state_q == StLoad) begin
      ptr_d = '0;
    end else if (enabled && (state_q == StRun) && !drain_req) begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        idx = CH_W'((int'(ptr_q) + k) % NUM_CHANNELS);
        if (!found && eligible[idx]) begin
          found        = 1'b1;
          grant_d[idx] = 1'b1;
          if (int'(idx) == NUM_CHANNELS - 1) ptr_d = '0;
          else                               ptr_d = idx + CH_W'(1);
        end
      end
    end
  end

  // Quota load, credit accounting and sticky error
  always_comb begin
    quota_d = quota_q;
    count_d = count_q;
    err_d   = err_q;
    rsp_hit = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      rsp_hit[i] = rsp_valid & (rsp_channel == CH_W'(i));
    end
    if (!enabled) begin
      count_d = '0;
    end else if (state_q == StLoad) begin
      quota_d = clamped;
      count_d = clamped;
      err_d   = (sum > limit);
    end else if (state_q != StIdle) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (rsp_hit[i] && !grant_q[i]) begin
          // A return with nothing outstanding saturates and flags the error
          if (count_q[i] >= quota_q[i]) err_d = 1'b1;
          else                          count_d[i] = count_q[i] + CNT_W'(1);
        end else if (grant_q[i] && !rsp_hit[i]) begin
          count_d[i] = count_q[i] - CNT_W'(1);
        end
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      cfg_q   <= '0;
      quota_q <= '0;
      count_q <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (cfg_accept) cfg_q <= cfg_credits;
      quota_q <= quota_d;
      count_q <= count_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_cmd_credit_pool_ctrl.sv
// Self-checking bench for cmd_credit_pool_ctrl.
module tb_cmd_credit_pool_ctrl;

  localparam int NC = 4;
  localparam int CW = 7;

  logic             clock = 1'b0;
  logic             rstn;
  logic             enabled;
  logic [7:0]       croom;
  logic [NC*CW-1:0] cfg_credits;
  logic             cfg_load;
  logic [NC-1:0]    req_valid;
  logic [NC-1:0]    grant;
  logic             rsp_valid;
  logic [1:0]       rsp_channel;
  logic             drain_req;
  logic             drain_done;
  logic [NC*CW-1:0] credits_avail;
  logic             cfg_error;

  int vectors;
  int miscompares;
  int exp_ch[$];
  bit exp_done[$];

  cmd_credit_pool_ctrl dut (
    .clock         (clock),
    .rstn          (rstn),
    .enabled       (enabled),
    .croom         (croom),
    .cfg_credits   (cfg_credits),
    .cfg_load      (cfg_load),
    .req_valid     (req_valid),
    .grant         (grant),
    .rsp_valid     (rsp_valid),
    .rsp_channel   (rsp_channel),
    .drain_req     (drain_req),
    .drain_done    (drain_done),
    .credits_avail (credits_avail),
    .cfg_error     (cfg_error)
  );

  always #5 clock = ~clock;

  function automatic logic [NC*CW-1:0] pack4(input int c0, input int c1, input int c2,
                                             input int c3);
    return {7'(c3), 7'(c2), 7'(c1), 7'(c0)};
  endfunction

  function automatic logic [CW-1:0] cred(input int ch);
    return credits_avail[ch*CW +: CW];
  endfunction

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic go_idle();
    enabled   = 1'b0;
    req_valid = '0;
    rsp_valid = 1'b0;
    drain_req = 1'b0;
    cfg_load  = 1'b0;
    step();
  endtask

  task automatic load(input int c0, input int c1, input int c2, input int c3, input int room);
    cfg_credits = pack4(c0, c1, c2, c3);
    croom       = 8'(room);
    enabled     = 1'b1;
    cfg_load    = 1'b1;
    step();
    cfg_load = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    vectors++;
    if (grant !== 4'b0) begin
      miscompares++; $display("FAIL reset_grant got %b exp 0000", grant);
    end
    vectors++;
    if (drain_done !== 1'b0) begin
      miscompares++; $display("FAIL reset_drain_done got %b exp 0", drain_done);
    end
    vectors++;
    if (cfg_error !== 1'b0) begin
      miscompares++; $display("FAIL reset_cfg_error got %b exp 0", cfg_error);
    end
    vectors++;
    if (credits_avail !== '0) begin
      miscompares++; $display("FAIL reset_credits got %h exp 0", credits_avail);
    end
    rstn      = 1'b1;
    enabled   = 1'b1;
    req_valid = 4'hf;
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++;
      if (grant !== 4'b0) begin
        miscompares++; $display("FAIL idle_no_grant got %b exp 0000", grant);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_rotation();
    int seq[19] = '{0, 1, 2, 3, 0, 1, 2, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    int e;
    go_idle();
    load(8, 8, 2, 1, 64);
    vectors++;
    if (credits_avail !== pack4(8, 8, 2, 1)) begin
      miscompares++; $display("FAIL rot_load got %h exp %h", credits_avail, pack4(8, 8, 2, 1));
    end
    vectors++;
    if (cfg_error !== 1'b0) begin
      miscompares++; $display("FAIL rot_cfg_error got %b exp 0", cfg_error);
    end
    exp_ch.delete();
    foreach (seq[i]) exp_ch.push_back(seq[i]);
    req_valid = 4'hf;
    for (int c = 0; c < 30; c++) begin
      step();
      if (grant !== 4'b0) begin
        vectors++;
        if (exp_ch.size() == 0) begin
          miscompares++; $display("FAIL rot_extra_grant got %b exp none", grant);
        end else begin
          e = exp_ch.pop_front();
          if (grant !== (4'b1 << e)) begin
            miscompares++; $display("FAIL rot_grant got %b exp %b", grant, 4'b1 << e);
          end
        end
      end
    end
    vectors++;
    if (exp_ch.size() != 0) begin
      miscompares++; $display("FAIL rot_missing_grants got %0d left exp 0", exp_ch.size());
    end
    vectors++;
    if (credits_avail !== '0) begin
      miscompares++; $display("FAIL rot_exhausted got %h exp 0", credits_avail);
    end
    req_valid = '0;
  endtask

  task automatic test_clamp();
    int cfg[6][5] = '{'{40, 40, 2, 2, 64}, '{10, 10, 10, 10, 25}, '{10, 10, 10, 10, 40},
                      '{64, 0, 0, 0, 200}, '{65, 3, 0, 0, 200}, '{0, 0, 0, 0, 0}};
    int qt[6][4]  = '{'{40, 24, 0, 0}, '{10, 10, 5, 0}, '{10, 10, 10, 10},
                      '{64, 0, 0, 0}, '{64, 0, 0, 0}, '{0, 0, 0, 0}};
    bit er[6]     = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [NC*CW-1:0] exp_cred;
    for (int t = 0; t < 6; t++) begin
      go_idle();
      load(cfg[t][0], cfg[t][1], cfg[t][2], cfg[t][3], cfg[t][4]);
      exp_cred = pack4(qt[t][0], qt[t][1], qt[t][2], qt[t][3]);
      vectors++;
      if (credits_avail !== exp_cred) begin
        miscompares++; $display("FAIL clamp_quota[%0d] got %h exp %h", t, credits_avail, exp_cred);
      end
      vectors++;
      if (cfg_error !== er[t]) begin
        miscompares++; $display("FAIL clamp_error[%0d] got %b exp %b", t, cfg_error, er[t]);
      end
    end
    // a load pulse while running must be ignored
    cfg_credits = pack4(5, 5, 5, 5);
    cfg_load    = 1'b1;
    step();
    cfg_load = 1'b0;
    step();
    step();
    vectors++;
    if (credits_avail !== '0) begin
      miscompares++; $display("FAIL load_in_run got %h exp 0", credits_avail);
    end
  endtask

  task automatic test_same_cycle_return();
    logic [3:0] exp_g;
    go_idle();
    load(1, 0, 0, 0, 64);
    req_valid   = 4'b0001;
    rsp_channel = 2'd0;
    for (int k = 0; k < 12; k++) begin
      exp_g = (k % 2 == 1) ? 4'b0001 : 4'b0000;
      vectors++;
      if (grant !== exp_g) begin
        miscompares++; $display("FAIL same_cycle_grant[%0d] got %b exp %b", k, grant, exp_g);
      end
      vectors++;
      if (cred(0) !== 7'd1) begin
        miscompares++; $display("FAIL same_cycle_count[%0d] got %0d exp 1", k, cred(0));
      end
      rsp_valid = grant[0];
      step();
    end
    rsp_valid = 1'b0;
    req_valid = '0;
    vectors++;
    if (cfg_error !== 1'b0) begin
      miscompares++; $display("FAIL same_cycle_error got %b exp 0", cfg_error);
    end
  endtask

  task automatic test_return_overflow();
    go_idle();
    load(8, 8, 0, 0, 64);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    vectors++;
    if (grant !== 4'b0010) begin
      miscompares++; $display("FAIL ovf_grant got %b exp 0010", grant);
    end
    step();
    vectors++;
    if (cred(1) !== 7'd7) begin
      miscompares++; $display("FAIL ovf_taken got %0d exp 7", cred(1));
    end
    rsp_valid   = 1'b1;
    rsp_channel = 2'd1;
    step();
    vectors++;
    if (cred(1) !== 7'd8 || cfg_error !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_legal_return got %0d/%b exp 8/0", cred(1), cfg_error);
    end
    step();
    rsp_valid = 1'b0;
    vectors++;
    if (cred(1) !== 7'd8 || cfg_error !== 1'b1) begin
      miscompares++; $display("FAIL ovf_extra_return got %0d/%b exp 8/1", cred(1), cfg_error);
    end
    vectors++;
    if (cred(0) !== 7'd8) begin
      miscompares++; $display("FAIL ovf_other_ch got %0d exp 8", cred(0));
    end
    step();
    step();
    vectors++;
    if (cfg_error !== 1'b1) begin
      miscompares++; $display("FAIL ovf_sticky got %b exp 1", cfg_error);
    end
  endtask

  task automatic test_drain();
    int seq[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0};
    int n;
    int e;
    bit d;
    go_idle();
    load(12, 4, 0, 0, 64);
    exp_ch.delete();
    foreach (seq[i]) exp_ch.push_back(seq[i]);
    n = 0;
    req_valid = 4'b0011;
    for (int c = 0; c < 40 && n < 10; c++) begin
      step();
      if (grant !== 4'b0) begin
        n++;
        vectors++;
        e = (exp_ch.size() != 0) ? exp_ch.pop_front() : 0;
        if (grant !== (4'b1 << e)) begin
          miscompares++; $display("FAIL drain_fill_grant got %b exp %b", grant, 4'b1 << e);
        end
        if (n == 10) req_valid = '0;
      end
    end
    vectors++;
    if (n != 10) begin
      miscompares++; $display("FAIL drain_fill_timeout got %0d grants exp 10", n);
    end
    req_valid = '0;
    step();
    vectors++;
    if (credits_avail !== pack4(6, 0, 0, 0)) begin
      miscompares++; $display("FAIL drain_outstanding got %h exp %h", credits_avail, pack4(6, 0, 0, 0));
    end
    drain_req = 1'b1;
    step();
    req_valid = 4'b0011;
    vectors++;
    if (drain_done !== 1'b0) begin
      miscompares++; $display("FAIL drain_early got %b exp 0", drain_done);
    end
    exp_done.delete();
    for (int j = 0; j < 10; j++) begin
      vectors++;
      if (grant !== 4'b0) begin
        miscompares++; $display("FAIL drain_grant[%0d] got %b exp 0000", j, grant);
      end
      rsp_valid   = 1'b1;
      rsp_channel = (j < 6) ? 2'd0 : 2'd1;
      exp_done.push_back(j == 9);
      step();
      d = exp_done.pop_front();
      vectors++;
      if (drain_done !== d) begin
        miscompares++; $display("FAIL drain_done[%0d] got %b exp %b", j, drain_done, d);
      end
    end
    rsp_valid = 1'b0;
    vectors++;
    if (credits_avail !== pack4(12, 4, 0, 0)) begin
      miscompares++; $display("FAIL drain_restored got %h exp %h", credits_avail, pack4(12, 4, 0, 0));
    end
    step();
    vectors++;
    if (drain_done !== 1'b1 || grant !== 4'b0) begin
      miscompares++; $display("FAIL drained_hold got %b/%b exp 1/0000", drain_done, grant);
    end
    drain_req = 1'b0;
    exp_ch.delete();
    exp_ch.push_back(1);
    n = 0;
    for (int c = 0; c < 6 && n == 0; c++) begin
      step();
      if (grant !== 4'b0) begin
        n = 1;
        req_valid = '0;
        e = exp_ch.pop_front();
        vectors++;
        if (grant !== (4'b1 << e)) begin
          miscompares++; $display("FAIL resume_grant got %b exp %b", grant, 4'b1 << e);
        end
      end
    end
    vectors++;
    if (n == 0) begin
      miscompares++; $display("FAIL resume_timeout got no grant exp %b", 4'b0010);
    end
    req_valid = '0;
  endtask

  task automatic test_disable();
    go_idle();
    load(4, 4, 4, 4, 64);
    req_valid = 4'hf;
    step();
    vectors++;
    if (grant !== 4'b0001) begin
      miscompares++; $display("FAIL dis_pending got %b exp 0001", grant);
    end
    enabled = 1'b0;
    #1;
    vectors++;
    if (grant !== 4'b0) begin
      miscompares++; $display("FAIL dis_mask got %b exp 0000", grant);
    end
    step();
    vectors++;
    if (credits_avail !== '0) begin
      miscompares++; $display("FAIL dis_zeroed got %h exp 0", credits_avail);
    end
    enabled = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      vectors++;
      if (grant !== 4'b0 || credits_avail !== '0) begin
        miscompares++; $display("FAIL dis_idle got %b/%h exp 0000/0", grant, credits_avail);
      end
    end
    req_valid = '0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstn        = 1'b0;
    enabled     = 1'b0;
    croom       = '0;
    cfg_credits = '0;
    cfg_load    = 1'b0;
    req_valid   = '0;
    rsp_valid   = 1'b0;
    rsp_channel = '0;
    drain_req   = 1'b0;
    test_reset();
    test_rotation();
    test_clamp();
    test_same_cycle_return();
    test_return_overflow();
    test_drain();
    test_disable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
